// File: rtl/tnet_cmd_dispatch_if.sv
// Signal bundle between the T-NET link controller, the command dispatcher and the core.
// The master side drives commands, sync, core ready and clear; the slave side is the dispatcher.
interface tnet_cmd_dispatch_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_req_i;
  logic [63:0]   cmd_h_i;
  logic [63:0]   cmd_dt_i;
  logic          sync_i;
  logic          core_vld_o;
  logic          core_rdy_i;
  logic [7:0]    core_op_o;
  logic [9:0]    core_src_o;
  logic [9:0]    core_step_o;
  logic [19:0]   core_arg_o;
  logic [63:0]   core_dt_o;
  logic          clr_i;
  logic [CW-1:0] fifo_cnt_o;
  logic [15:0]   drop_cnt_o;
  logic [15:0]   nop_cnt_o;
  logic          sync_to_o;
  logic [1:0]    debug_do;

  modport master (
    output cmd_req_i, cmd_h_i, cmd_dt_i, sync_i, core_rdy_i, clr_i,
    input  core_vld_o, core_op_o, core_src_o, core_step_o, core_arg_o, core_dt_o,
    input  fifo_cnt_o, drop_cnt_o, nop_cnt_o, sync_to_o, debug_do
  );

  modport slave (
    input  cmd_req_i, cmd_h_i, cmd_dt_i, sync_i, core_rdy_i, clr_i,
    output core_vld_o, core_op_o, core_src_o, core_step_o, core_arg_o, core_dt_o,
    output fifo_cnt_o, drop_cnt_o, nop_cnt_o, sync_to_o, debug_do
  );
endinterface

// File: rtl/tnet_cmd_dispatch.sv
// T-NET command dispatcher: buffers link commands in a FIFO, drops NOPs, holds sync-flagged
// commands until the sync tick (or timeout) and hands them to the core on valid/ready.
module tnet_cmd_dispatch #(
  parameter int DEPTH   = 8,
  parameter int SYNC_TO = 1024
) (
  input  logic                  user_clk_i,
  input  logic                  user_rst_i,
  tnet_cmd_dispatch_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    WAIT_SYNC = 2'd2,
    ISSUE     = 2'd3
  } state_t;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [127:0]  hold_reg;
  logic [15:0]   tmo_reg;
  logic [15:0]   drop_reg;
  logic [15:0]   nop_reg;
  logic          sto_reg;
  state_t        state_reg;
  state_t        state_next;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          nop_inc;
  logic          tmo_clr;
  logic          tmo_step;
  logic          tmo_fire;
  logic          vld;
  logic [16:0]   tmo_inc;
  logic          tmo_hit;
  logic [7:0]    hold_op;
  logic          hold_sync;
  logic          unused_hold_bits;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  // Full is judged on the registered occupancy, so a pop in the same cycle cannot rescue a write.
  assign push      = bus.cmd_req_i && !full;
  assign hold_op   = hold_reg[127:120];
  assign hold_sync = hold_reg[119];
  assign tmo_inc   = {1'b0, tmo_reg} + 17'd1;
  assign tmo_hit   = (tmo_inc == 17'(SYNC_TO));
  assign unused_hold_bits = ^{hold_reg[118:114], hold_reg[113:104]};

  always_ff @(posedge user_clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.cmd_h_i, bus.cmd_dt_i};
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        hold_reg   <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!empty) state_next = DECODE;
      end
      DECODE: begin
        if (hold_op == 8'h00)  state_next = IDLE;
        else if (hold_sync)    state_next = WAIT_SYNC;
        else                   state_next = ISSUE;
      end
      WAIT_SYNC: begin
        // A sync tick in the timeout cycle still wins.
        if (bus.sync_i)        state_next = ISSUE;
        else if (tmo_hit)      state_next = IDLE;
      end
      ISSUE: begin
        if (bus.core_rdy_i)    state_next = IDLE;
      end
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    nop_inc  = 1'b0;
    tmo_clr  = 1'b0;
    tmo_step = 1'b0;
    tmo_fire = 1'b0;
    vld      = 1'b0;
    case (state_reg)
      IDLE:      pop      = !empty;
      DECODE: begin
        nop_inc = (hold_op == 8'h00);
        tmo_clr = 1'b1;
      end
      WAIT_SYNC: begin
        tmo_step = !bus.sync_i;
        tmo_fire = !bus.sync_i && tmo_hit;
      end
      ISSUE:     vld      = 1'b1;
      default:   vld      = 1'b0;
    endcase
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      tmo_reg <= '0;
    end else if (tmo_clr) begin
      tmo_reg <= '0;
    end else if (tmo_step) begin
      tmo_reg <= tmo_inc[15:0];
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      drop_reg <= '0;
      nop_reg  <= '0;
      sto_reg  <= 1'b0;
    end else if (bus.clr_i) begin
      drop_reg <= '0;
      nop_reg  <= '0;
      sto_reg  <= 1'b0;
    end else begin
      if (bus.cmd_req_i && full && (drop_reg != 16'hFFFF)) drop_reg <= drop_reg + 16'd1;
      if (nop_inc && (nop_reg != 16'hFFFF))                nop_reg  <= nop_reg + 16'd1;
      if (tmo_fire)                                        sto_reg  <= 1'b1;
    end
  end

  assign bus.core_vld_o  = vld;
  assign bus.core_op_o   = hold_reg[127:120];
  assign bus.core_src_o  = hold_reg[103:94];
  assign bus.core_step_o = hold_reg[93:84];
  assign bus.core_arg_o  = hold_reg[83:64];
  assign bus.core_dt_o   = hold_reg[63:0];
  assign bus.fifo_cnt_o  = count_reg;
  assign bus.drop_cnt_o  = drop_reg;
  assign bus.nop_cnt_o   = nop_reg;
  assign bus.sync_to_o   = sto_reg;
  assign bus.debug_do    = state_reg;
endmodule

// File: tb/tb_tnet_cmd_dispatch.sv
// Self-checking bench for tnet_cmd_dispatch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_tnet_cmd_dispatch;
  localparam int DEPTH   = 8;
  localparam int SYNC_TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tnet_cmd_dispatch_if #(.DEPTH(DEPTH)) bus ();

  tnet_cmd_dispatch #(.DEPTH(DEPTH), .SYNC_TO(SYNC_TO)) dut (
    .user_clk_i (clk),
    .user_rst_i (rst),
    .bus        (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: a queue for the FIFO, the command in service and its phase.
  logic [127:0] mq[$];
  logic [127:0] delivered[$];
  logic [127:0] m_cur;
  int           m_ph;
  int           m_wait;
  int           m_drop;
  int           m_nop;
  bit           m_sto;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] mk_h(input logic [7:0] op, input logic [5:0] flags,
                                       input logic [9:0] src, input logic [9:0] step,
                                       input logic [19:0] arg);
    return {op, flags, 10'h3A5, src, step, arg};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur  = '0;
    m_ph   = 0;
    m_wait = 0;
    m_drop = 0;
    m_nop  = 0;
    m_sto  = 1'b0;
  endtask

  task automatic model_step();
    int  size0;
    int  ph_n;
    bit  d_inc;
    bit  n_inc;
    bit  s_set;
    if (rst) return;
    size0 = mq.size();
    ph_n  = m_ph;
    d_inc = 1'b0;
    n_inc = 1'b0;
    s_set = 1'b0;
    case (m_ph)
      0: if (size0 > 0) begin m_cur = mq.pop_front(); ph_n = 1; end
      1: begin
        if (m_cur[127:120] == 8'h00) begin n_inc = 1'b1; ph_n = 0; end
        else if (m_cur[119])         begin m_wait = 0;   ph_n = 2; end
        else                         ph_n = 3;
      end
      2: begin
        if (bus.sync_i) ph_n = 3;
        else begin
          m_wait++;
          if (m_wait == SYNC_TO) begin s_set = 1'b1; ph_n = 0; end
        end
      end
      default: begin
        if (bus.core_rdy_i) begin
          delivered.push_back(m_cur);
          $display("deliver op=%02h src=%0d step=%0d arg=%05h dt=%016h",
                   m_cur[127:120], m_cur[103:94], m_cur[93:84], m_cur[83:64], m_cur[63:0]);
          ph_n = 0;
        end
      end
    endcase
    if (bus.cmd_req_i) begin
      if (size0 == DEPTH) d_inc = 1'b1;
      else mq.push_back({bus.cmd_h_i, bus.cmd_dt_i});
    end
    if (bus.clr_i) begin
      m_drop = 0;
      m_nop  = 0;
      m_sto  = 1'b0;
    end else begin
      if (d_inc) m_drop = sat_inc(m_drop);
      if (n_inc) m_nop  = sat_inc(m_nop);
      if (s_set) m_sto  = 1'b1;
    end
    m_ph = ph_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    int k;
    k = 0;
    while (bus.debug_do !== s && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 64'(bus.debug_do), 64'(s));
  endtask

  task automatic send(input logic [63:0] h, input logic [63:0] dt);
    bus.cmd_req_i = 1'b1;
    bus.cmd_h_i   = h;
    bus.cmd_dt_i  = dt;
    tick();
    bus.cmd_req_i = 1'b0;
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    chk("vld",      64'(bus.core_vld_o), 64'(m_ph == 3));
    chk("state",    64'(bus.debug_do),   64'(m_ph));
    chk("fifo_cnt", 64'(bus.fifo_cnt_o), 64'(mq.size()));
    chk("drop_cnt", 64'(bus.drop_cnt_o), 64'(m_drop));
    chk("nop_cnt",  64'(bus.nop_cnt_o),  64'(m_nop));
    chk("sync_to",  64'(bus.sync_to_o),  64'(m_sto));
    if (m_ph == 3) begin
      chk("op",   64'(bus.core_op_o),   64'(m_cur[127:120]));
      chk("src",  64'(bus.core_src_o),  64'(m_cur[103:94]));
      chk("step", 64'(bus.core_step_o), 64'(m_cur[93:84]));
      chk("arg",  64'(bus.core_arg_o),  64'(m_cur[83:64]));
      chk("dt",   bus.core_dt_o,        m_cur[63:0]);
    end
  end

  initial begin
    int base;
    logic [7:0] op;
    logic [5:0] flags;
    bus.cmd_req_i  = 1'b0;
    bus.cmd_h_i    = '0;
    bus.cmd_dt_i   = '0;
    bus.sync_i     = 1'b0;
    bus.core_rdy_i = 1'b0;
    bus.clr_i      = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_vld",  64'(bus.core_vld_o), 64'd0);
    chk("rst_cnt",  64'(bus.fifo_cnt_o), 64'd0);
    chk("rst_dbg",  64'(bus.debug_do),   64'd0);

    // Single plain command, minimum latency.
    bus.core_rdy_i = 1'b1;
    send(mk_h(8'h05, 6'd0, 10'd3, 10'd2, 20'h00ABC), 64'h1234);
    chk("t1_e0_vld", 64'(bus.core_vld_o), 64'd0);
    tick();
    chk("t1_e1_vld", 64'(bus.core_vld_o), 64'd0);
    tick();
    chk("t1_e2_vld", 64'(bus.core_vld_o), 64'd1);
    chk("t1_op",     64'(bus.core_op_o),  64'h05);
    chk("t1_src",    64'(bus.core_src_o), 64'd3);
    chk("t1_step",   64'(bus.core_step_o), 64'd2);
    chk("t1_arg",    64'(bus.core_arg_o), 64'h00ABC);
    chk("t1_dt",     bus.core_dt_o,       64'h1234);
    tick();
    chk("t1_vld_off", 64'(bus.core_vld_o), 64'd0);
    chk("t1_cnt",     64'(bus.fifo_cnt_o), 64'd0);

    // Ten back-to-back strobes against a stalled core.
    bus.core_rdy_i = 1'b0;
    base = delivered.size();
    bus.cmd_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.cmd_h_i  = mk_h(8'h10 + 8'(i), 6'd0, 10'(i), 10'(i + 1), 20'(i * 3));
      bus.cmd_dt_i = 64'hA000 + 64'(i);
      tick();
    end
    bus.cmd_req_i = 1'b0;
    chk("t2_drop", 64'(bus.drop_cnt_o), 64'd1);
    chk("t2_cnt",  64'(bus.fifo_cnt_o), 64'd8);
    bus.core_rdy_i = 1'b1;
    repeat (40) tick();
    chk("t2_ndeliv", 64'(delivered.size() - base), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (base + i < delivered.size()) chk("t2_order", 64'(delivered[base + i][103:94]), 64'(i));
    end

    // NOP is swallowed; the following command still goes out.
    send(mk_h(8'h00, 6'd0, 10'd4, 10'd0, 20'd0), 64'h0);
    repeat (3) tick();
    chk("t3_nop", 64'(bus.nop_cnt_o), 64'd1);
    send(mk_h(8'h07, 6'd0, 10'd11, 10'd1, 20'h12345), 64'hDEAD);
    repeat (4) tick();
    chk("t3_op7", 64'(delivered[delivered.size() - 1][127:120]), 64'h07);

    // Sync-flagged command released by a sync tick.
    send(mk_h(8'h21, 6'b100000, 10'd6, 10'd3, 20'd9), 64'hBEEF);
    wait_state(2'd2, 10, "t4_wait");
    repeat (10) tick();
    bus.sync_i = 1'b1;
    tick();
    bus.sync_i = 1'b0;
    chk("t4_sync_vld", 64'(bus.core_vld_o), 64'd1);
    tick();

    // Sync-flagged command with no tick times out.
    send(mk_h(8'h22, 6'b100000, 10'd7, 10'd3, 20'd9), 64'hCAFE);
    wait_state(2'd2, 10, "t4b_wait");
    repeat (SYNC_TO - 1) tick();
    chk("t4b_sto_pre", 64'(bus.sync_to_o), 64'd0);
    tick();
    chk("t4b_sto",  64'(bus.sync_to_o), 64'd1);
    chk("t4b_idle", 64'(bus.debug_do),  64'd0);

    // Long stall: valid and fields must hold.
    bus.core_rdy_i = 1'b0;
    send(mk_h(8'h42, 6'd0, 10'd5, 10'd8, 20'hFEDCB), 64'h0123456789ABCDEF);
    wait_state(2'd3, 10, "t5_issue");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t5_vld", 64'(bus.core_vld_o), 64'd1);
      chk("t5_op",  64'(bus.core_op_o),  64'h42);
      chk("t5_arg", 64'(bus.core_arg_o), 64'hFEDCB);
      chk("t5_dt",  bus.core_dt_o,       64'h0123456789ABCDEF);
    end
    bus.cmd_req_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_h_i = mk_h(8'h50, 6'd0, 10'(20 + i), 10'd0, 20'd0);
      tick();
    end
    chk("t5_full", 64'(bus.fifo_cnt_o), 64'd8);
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i     = 1'b0;
    bus.cmd_req_i = 1'b0;
    chk("t5_clr_drop", 64'(bus.drop_cnt_o), 64'd0);
    chk("t5_clr_nop",  64'(bus.nop_cnt_o),  64'd0);
    chk("t5_clr_sto",  64'(bus.sync_to_o),  64'd0);

    // Asynchronous reset while issuing with a full queue.
    #2;
    rst = 1'b1;
    #1;
    chk("t6_vld", 64'(bus.core_vld_o), 64'd0);
    chk("t6_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    chk("t6_dbg", 64'(bus.debug_do),   64'd0);
    chk("t6_op",  64'(bus.core_op_o),  64'd0);
    chk("t6_dt",  bus.core_dt_o,       64'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("t6_cnt_after", 64'(bus.fifo_cnt_o), 64'd0);
    bus.core_rdy_i = 1'b1;
    send(mk_h(8'h33, 6'd0, 10'd9, 10'd1, 20'd1), 64'h99);
    tick();
    tick();
    chk("t6_vld_new", 64'(bus.core_vld_o), 64'd1);
    chk("t6_src_new", 64'(bus.core_src_o), 64'd9);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      op    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      flags = 6'($urandom);
      flags[5] = ($urandom_range(0, 3) == 0);
      bus.cmd_req_i  = ($urandom_range(0, 9) < 4);
      bus.cmd_h_i    = mk_h(op, flags, 10'($urandom), 10'($urandom), 20'($urandom));
      bus.cmd_dt_i   = {$urandom, $urandom};
      bus.sync_i     = ($urandom_range(0, 11) == 0);
      bus.core_rdy_i = ($urandom_range(0, 9) < 7);
      bus.clr_i      = ($urandom_range(0, 49) == 0);
      tick();
    end
    bus.cmd_req_i = 1'b0;
    bus.sync_i    = 1'b0;
    bus.clr_i     = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
